// File: rtl/ring_meas_pkg.sv
// Shared definitions for the ring-oscillator measurement blocks:
// state encoding, default parameters and small elaboration helpers.
package ring_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } meas_state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_GATE_CYCLES   = 1024;
  localparam int DEF_CNT_W         = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ring_osc_meter_if.sv
// Requester-side handshake of the ring oscillator meter: start/ack in,
// busy and the held result (count, ovf, count_valid) out.
interface ring_osc_meter_if #(
  parameter int CNT_W = 16
);
  // Handshake: start is honoured only while the meter is idle; count/ovf are
  // valid while count_valid=1 and are held until ack=1 is seen in that state.
  logic             start;
  logic             ack;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             count_valid;

  modport master (
    output start,
    output ack,
    input  busy,
    input  count,
    input  ovf,
    input  count_valid
  );

  modport slave (
    input  start,
    input  ack,
    output busy,
    output count,
    output ovf,
    output count_valid
  );

endinterface

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; output is the last
// stage. Always clocked, reset to 0.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/ring_osc_meter.sv
// Ring oscillator controller: enables the oscillator, lets it settle, counts
// its synchronized rising edges over a fixed clk window, and holds the result.
module ring_osc_meter
  import ring_meas_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              osc_in,
  output logic              osc_en,
  output meas_state_t       state_dbg,
  ring_osc_meter_if.slave   bus
);

  localparam int TMR_W = $clog2(max_int(SETTLE_CYCLES, GATE_CYCLES)) + 1;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic osc_s;
  logic rise;

  meas_state_t      state_q,  state_d;
  logic [TMR_W-1:0] timer_q,  timer_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             p_q,      p_d;
  logic             osc_en_q, osc_en_d;
  logic             busy_q,   busy_d;
  logic             valid_q,  valid_d;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (osc_in),
    .q     (osc_s)
  );

  assign rise = osc_s & ~p_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    p_d     = osc_s;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = WARMUP;
          timer_d = SETTLE_LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      WARMUP: begin
        if (timer_q == '0) begin
          state_d = MEASURE;
          timer_d = GATE_LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      MEASURE: begin
        // The final window cycle's edge is still counted before leaving.
        if (rise) begin
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        if (timer_q == '0) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DONE: begin
        if (bus.ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it.
    osc_en_d = (state_d == WARMUP) || (state_d == MEASURE);
    busy_d   = (state_d != IDLE);
    valid_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      p_q      <= 1'b0;
      osc_en_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      p_q      <= p_d;
      osc_en_q <= osc_en_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign osc_en          = osc_en_q;
  assign state_dbg       = state_q;
  assign bus.busy        = busy_q;
  assign bus.count       = count_q;
  assign bus.ovf         = ovf_q;
  assign bus.count_valid = valid_q;

endmodule
